// File: rtl/ps2kb_pkg.sv
// Shared constants, frame-state encoding and key-event layout for the PS/2 keyboard receiver.
package ps2kb_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_PAUSE = 8'hE1;

   localparam int KEY_BRK_BIT = 9;
   localparam int KEY_EXT_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   // Keyboard replies and the pause prefix carry no key information.
   function automatic logic is_drop_code(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, SC_PAUSE: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame deframer: synchronise, filter the clock,
// sample data on filtered falling edges, check parity/stop and abandon stalled frames.
module ps2_rx_frame
   import ps2kb_pkg::*;
#(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       perr
);

   localparam int FCW = $clog2(FILT_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

   logic [1:0]     clk_sync;
   logic [1:0]     dat_sync;
   logic           filt_clk;
   logic [FCW-1:0] filt_cnt;
   logic           fall;

   frame_state_e   state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           par;
   logic [TCW-1:0] to_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         fall     <= 1'b0;
         // Any sample matching the current level restarts the run, so short glitches never count.
         if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
            fall     <= filt_clk;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         to_cnt   <= '0;
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         perr     <= 1'b0;
      end else begin
         byte_vld <= 1'b0;
         perr     <= 1'b0;

         if (state != ST_IDLE && !fall) begin
            if (to_cnt == TO_LAST) begin
               state  <= ST_IDLE;
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end

         if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!dat_sync[1]) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  shreg   <= {dat_sync[1], shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par   <= dat_sync[1];
                  state <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  if (dat_sync[1] && ^{shreg, par}) begin
                     rx_byte  <= shreg;
                     byte_vld <= 1'b1;
                  end else begin
                     perr <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2kb_rx.sv
// PS/2 keyboard receiver: set-2 prefix decoding plus a polled key-event FIFO
// presented as a registered head word for the bus.
module ps2kb_rx
   import ps2kb_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FILT_LEN   = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       ps2kb_ack,
   output logic [9:0] ps2kb_key,
   output logic       ps2kb_ready,
   output logic       ps2kb_overflow,
   output logic       ps2kb_perr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [7:0]    rx_byte;
   logic          byte_vld;
   logic          rx_perr;

   logic          ext_f;
   logic          brk_f;
   logic          push;
   logic [9:0]    wdata;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          ack_q;
   logic          pop;
   logic          full;
   logic          wr_en;
   logic [9:0]    head_nxt;

   ps2_rx_frame #(
      .FILT_LEN (FILT_LEN),
      .TIMEOUT  (TIMEOUT)
   ) u_frame (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .perr     (rx_perr)
   );

   assign ps2kb_perr = rx_perr;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      push = 1'b0;
      wdata = '0;
      wdata[KEY_BRK_BIT] = brk_f;
      wdata[KEY_EXT_BIT] = ext_f;
      wdata[7:0] = rx_byte;
      if (byte_vld && rx_byte != SC_EXT && rx_byte != SC_BRK && !is_drop_code(rx_byte))
         push = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext_f <= 1'b0;
         brk_f <= 1'b0;
      end else if (rx_perr) begin
         ext_f <= 1'b0;
         brk_f <= 1'b0;
      end else if (byte_vld) begin
         case (rx_byte)
            SC_EXT:  ext_f <= 1'b1;
            SC_BRK:  brk_f <= 1'b1;
            default: begin
               ext_f <= 1'b0;
               brk_f <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      full  = (count == FULL_CNT);
      pop   = ps2kb_ack && !ack_q && (count != '0);
      wr_en = push && (!full || pop);
      rd_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
      count_nxt = count;
      if (wr_en && !pop)      count_nxt = count + 1'b1;
      else if (!wr_en && pop) count_nxt = count - 1'b1;
      // The new head bypasses memory when it is the word being written this cycle.
      head_nxt = '0;
      if (count_nxt != '0) begin
         if (count == '0 || (pop && count == CW'(1))) head_nxt = wdata;
         else                                         head_nxt = mem[rd_nxt];
      end
   end

   // NOTE: storage array has no reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q          <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         ps2kb_key      <= '0;
         ps2kb_ready    <= 1'b0;
         ps2kb_overflow <= 1'b0;
      end else begin
         ack_q       <= ps2kb_ack;
         rd_ptr      <= rd_nxt;
         count       <= count_nxt;
         ps2kb_key   <= head_nxt;
         ps2kb_ready <= (count_nxt != '0);
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (push && full && !pop)        ps2kb_overflow <= 1'b1;
         else if (pop && count_nxt == '0) ps2kb_overflow <= 1'b0;
      end
   end

endmodule
